// File: rtl/ram_loader.sv
// ram_loader: streams words into a DEPTH x DATA_W register array in
// address order, then blocks further writes until restarted. An
// independent registered read port works in every state.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse, restarts loading at address 0
//   in_valid/in_data    write stream; in_ready says a word is taken this cycle
//   rd_en/rd_addr       read request; rd_data/rd_valid one cycle later
//   wr_count            words written since reset/start (0..DEPTH)
//   done                high while all DEPTH entries are written
module ram_loader #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [AW:0]       wr_count,
  output logic              done
);

  typedef enum logic {LOAD = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr;
  logic                wr_en;
  logic [DATA_W-1:0]   mem [DEPTH];

  // start masks the handshake so a word presented with start is not consumed
  assign in_ready = (state_q == LOAD) && !start;
  assign wr_en    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (start)
      state_d = LOAD;
    else if (wr_en && wr_ptr == AW'(DEPTH-1))
      state_d = FULL;
  end

  // done tracks the next state so it is high in the same cycle state is FULL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      done     <= 1'b0;
      wr_ptr   <= '0;
      wr_count <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_d == FULL);
      if (start) begin
        wr_ptr   <= '0;
        wr_count <= '0;
      end else if (wr_en) begin
        wr_ptr   <= wr_ptr + AW'(1);
        wr_count <= wr_count + (AW+1)'(1);
      end
    end
  end

  // Array and read port share a block; nonblocking update means a read that
  // collides with a write to the same entry sees the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en) mem[wr_ptr] <= in_data;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter DATA_W, default 4: data word width in bits.
REQ-002 Parameter DEPTH, default 8: number of entries; fixed power of two; AW = log2(DEPTH) = 3.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse; restarts loading at address 0.
REQ-006 in_valid  in  1  write-stream word present.
REQ-007 in_data  in  DATA_W  write-stream word.
REQ-008 in_ready  out  1  loader accepts a word this cycle.
REQ-009 rd_en  in  1  read request.
REQ-010 rd_addr  in  AW  read address.
REQ-011 rd_data  out  DATA_W  registered read data.
REQ-012 rd_valid  out  1  rd_data valid this cycle.
REQ-013 wr_count  out  AW+1  number of words written since the last reset or start, range 0..DEPTH.
REQ-014 done  out  1  high while all DEPTH entries are written.

Function
REQ-015 Storage: DEPTH x DATA_W register array.
REQ-016 Two states:
- LOAD: accepting words.
- FULL: array complete, writes blocked.
REQ-017 in_ready = (state==LOAD) && !start; it is combinational.
REQ-018 Handshake: a word transfers on a rising edge where in_valid && in_ready.
- in_data is written to entry wr_ptr.
- wr_ptr and wr_count each increment by 1.
REQ-019 in_valid with in_ready low: no write; the word is neither consumed nor buffered.
REQ-020 LOAD -> FULL on the transfer that writes entry DEPTH-1.
- wr_count becomes DEPTH.
- done rises the next cycle. wr_ptr wraps to 0 but is unused in FULL.
REQ-021 FULL holds until start or reset; in_ready stays 0 in FULL.
REQ-022 start (any state) forces, on that edge:
- state = LOAD, wr_ptr = 0, wr_count = 0, done = 0.
- Array contents are retained, not cleared.
- Any word presented in the same cycle is not written.
REQ-023 Read: rd_en high at edge N gives rd_data = array[rd_addr] and rd_valid = 1 after edge N, a 1-cycle latency.
- rd_en low: rd_valid = 0 and rd_data holds its last value.
REQ-024 Read and write to the same address on the same edge: rd_data returns the pre-write (old) contents.
REQ-025 Reads are permitted in every state and do not affect load state.
REQ-026 done = (state==FULL); it is registered and derived from state with no extra latency.

Reset
REQ-027 rst_n low asynchronously sets:
- state = LOAD, wr_ptr = 0, wr_count = 0, done = 0.
- rd_valid = 0, rd_data = 0, all array entries = 0.
REQ-028 After reset deassertion, in_ready = 1 provided start is low.
REQ-029 Reset asserted mid-load discards partial progress. No write occurs on an edge coincident with reset assertion.

Verification
REQ-030 Basic load: after reset, stream 0,2,4,..,14 with in_valid held high.
- in_ready is high for 8 cycles and wr_count steps 1..8.
- done = 1 after the 8th transfer; in_ready = 0 afterward.
- Reads of addresses 0..7 return 0,2,..,14, each 1 cycle after rd_en.
REQ-031 Back-pressure and gaps: toggle in_valid randomly across 8 words. Exactly 8 writes occur, in order, with no duplicates or drops; in_valid while FULL is ignored (word 9 = 4'hF never appears).
REQ-032 Restart mid-stream: load 3 words (A,B,C), then pulse start with in_valid=1, in_data=4'h5.
- 4'h5 is not written; wr_count = 0.
- The next word D lands at address 0; entries 1,2 still read B,C.
REQ-033 Read-during-write collision: during load, rd_en=1 with rd_addr = current wr_ptr while writing 4'h9 over old 4'h3. rd_data = 4'h3 next cycle; a later read returns 4'h9.
REQ-034 Async reset mid-load: assert rst_n low between clock edges after 5 words.
- Immediately: done = 0, rd_valid = 0, wr_count = 0.
- After release, all entries read 0 and in_ready = 1.
